// File: rtl/bitwise_pkg.sv
// bitwise_pkg: opcodes, data width and FSM encoding shared by the bitwise ALU driver
package bitwise_pkg;
    localparam int DATA_W = 7;
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
endpackage

// File: rtl/bitwise_op_driver_if.sv
// bitwise_op_driver_if: operand/opcode/result bus between the driver and the registered bitwise ALU
interface bitwise_op_driver_if #(parameter int W = bitwise_pkg::DATA_W);
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_q;
    modport master (output alu_a, alu_b, alu_op, input alu_q);
    modport slave (input alu_a, alu_b, alu_op, output alu_q);
endinterface

// File: rtl/bitwise_tag_pipe.sv
// bitwise_tag_pipe: delays {valid, op} by DEPTH clocks so each ALU result is matched to its opcode
module bitwise_tag_pipe #(parameter int DEPTH = 2) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_v,
    input  logic [1:0] in_op,
    output logic       out_v,
    output logic [1:0] out_op
);
    logic [DEPTH-1:0][2:0] sr;
    always_ff @(posedge clk or posedge rst)
        if (rst) sr <= '0;
        else begin
            sr[0] <= {in_v, in_op};
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    assign {out_v, out_op} = sr[DEPTH-1];
endmodule

// File: rtl/bitwise_op_driver.sv
// bitwise_op_driver: latches one operand pair, issues AND/OR/XOR/NAND back-to-back to a registered ALU,
// captures each result by its tag and pulses done once all four are in
module bitwise_op_driver import bitwise_pkg::*; #(
    parameter int WIDTH   = DATA_W,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    bitwise_op_driver_if.master alu,
    output logic [WIDTH-1:0] res_and,
    output logic [WIDTH-1:0] res_or,
    output logic [WIDTH-1:0] res_xor,
    output logic [WIDTH-1:0] res_nand,
    output logic             busy,
    output logic             done
);
    state_t state, state_n;
    logic [1:0] op, op_n, tag_op;
    logic [WIDTH-1:0] a_q, b_q;
    logic ld, iss, fin, tag_v;
    assign alu.alu_a  = a_q;
    assign alu.alu_b  = b_q;
    assign alu.alu_op = op;
    bitwise_tag_pipe #(.DEPTH(ALU_LAT + 1)) u_tag (
        .clk(clk), .rst(rst), .in_v(iss), .in_op(op_n), .out_v(tag_v), .out_op(tag_op)
    );
    // the run ends on the capture of the NAND tag, not on a cycle count, so it tracks ALU_LAT
    always_comb begin
        ld      = state == IDLE && start;
        iss     = ld || state == ISSUE;
        fin     = state == DRAIN && tag_v && tag_op == OP_NAND;
        op_n    = (ld || fin) ? OP_AND : state == ISSUE ? op + 2'd1 : op;
        state_n = ld ? ISSUE : (state == ISSUE && op == OP_XOR) ? DRAIN : fin ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            op       <= OP_AND;
            a_q      <= '0;
            b_q      <= '0;
            res_and  <= '0;
            res_or   <= '0;
            res_xor  <= '0;
            res_nand <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_n;
            op    <= op_n;
            if (ld) begin
                a_q <= a_in;
                b_q <= b_in;
            end
            busy <= ld | (busy & ~fin);
            done <= fin;
            if (tag_v && tag_op == OP_AND)  res_and  <= alu.alu_q;
            if (tag_v && tag_op == OP_OR)   res_or   <= alu.alu_q;
            if (tag_v && tag_op == OP_XOR)  res_xor  <= alu.alu_q;
            if (tag_v && tag_op == OP_NAND) res_nand <= alu.alu_q;
        end
endmodule

// File: tb/tb_bitwise_op_driver.sv
// tb_bitwise_op_driver: directed bench with a registered bitwise ALU model and a result scoreboard
module tb_bitwise_op_driver;
    import bitwise_pkg::*;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [6:0] a_in = '0, b_in = '0;
    logic [6:0] res_and, res_or, res_xor, res_nand;
    logic busy, done;
    int tests = 0, fails = 0, dones = 0;
    typedef struct {logic [6:0] a, o, x, n;} res_t;
    res_t sbq[$];

    bitwise_op_driver_if #(.W(7)) bus ();

    bitwise_op_driver #(.WIDTH(7), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .alu(bus),
        .res_and(res_and), .res_or(res_or), .res_xor(res_xor), .res_nand(res_nand),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // registered ALU partner, one clock of latency
    always @(posedge clk)
        case (bus.alu_op)
            OP_AND:  bus.alu_q <= bus.alu_a & bus.alu_b;
            OP_OR:   bus.alu_q <= bus.alu_a | bus.alu_b;
            OP_XOR:  bus.alu_q <= bus.alu_a ^ bus.alu_b;
            default: bus.alu_q <= ~(bus.alu_a & bus.alu_b);
        endcase

    function automatic res_t expect_of(logic [6:0] a, logic [6:0] b);
        res_t r;
        r.a = a & b;
        r.o = a | b;
        r.x = a ^ b;
        r.n = ~(a & b);
        return r;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        res_t e;
        @(posedge clk);
        #1;
        if (done) begin
            dones++;
            chk("sb_pending", int'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("res_and", int'(res_and), int'(e.a));
                chk("res_or", int'(res_or), int'(e.o));
                chk("res_xor", int'(res_xor), int'(e.x));
                chk("res_nand", int'(res_nand), int'(e.n));
            end
        end
    endtask

    task automatic run(logic [6:0] a, logic [6:0] b);
        int d0, n;
        a_in = a;
        b_in = b;
        start = 1'b1;
        sbq.push_back(expect_of(a, b));
        tick();
        start = 1'b0;
        d0 = dones;
        n = 0;
        while (dones == d0 && n < 12) begin
            tick();
            n++;
        end
        chk("run_latency", n, 5);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_alu_a"}, int'(bus.alu_a), 0);
        chk({tag, "_alu_b"}, int'(bus.alu_b), 0);
        chk({tag, "_alu_op"}, int'(bus.alu_op), 0);
        chk({tag, "_res"}, int'({res_and, res_or, res_xor, res_nand}), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int d0, t1, t2;
        #1 rst = 1'b1;
        #2 chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        // single run with per-edge opcode, busy and done checks
        a_in = 7'h55;
        b_in = 7'h0F;
        start = 1'b1;
        sbq.push_back(expect_of(7'h55, 7'h0F));
        d0 = dones;
        tick();
        start = 1'b0;
        chk("e0_op", int'(bus.alu_op), 0);
        chk("e0_busy", int'(busy), 1);
        chk("e0_alu_a", int'(bus.alu_a), 'h55);
        chk("e0_alu_b", int'(bus.alu_b), 'h0F);
        tick();
        chk("e1_op", int'(bus.alu_op), 1);
        chk("e1_busy", int'(busy), 1);
        tick();
        chk("e2_op", int'(bus.alu_op), 2);
        tick();
        chk("e3_op", int'(bus.alu_op), 3);
        chk("e3_done", int'(done), 0);
        tick();
        chk("e4_busy", int'(busy), 1);
        chk("e4_done", int'(done), 0);
        tick();
        chk("e5_done", int'(done), 1);
        chk("e5_busy", int'(busy), 0);
        chk("e5_op", int'(bus.alu_op), 0);
        tick();
        chk("e6_done", int'(done), 0);
        chk("e6_alu_a_hold", int'(bus.alu_a), 'h55);
        chk("one_done", dones - d0, 1);
        // all-ones and all-zeros operands
        run(7'h7F, 7'h7F);
        run(7'h00, 7'h00);
        // start while busy is ignored
        d0 = dones;
        a_in = 7'h11;
        b_in = 7'h22;
        start = 1'b1;
        sbq.push_back(expect_of(7'h11, 7'h22));
        tick();
        a_in = 7'h33;
        b_in = 7'h44;
        tick();
        tick();
        chk("busy_hold_a", int'(bus.alu_a), 'h11);
        chk("busy_hold_b", int'(bus.alu_b), 'h22);
        start = 1'b0;
        repeat (8) tick();
        chk("busy_one_done", dones - d0, 1);
        // async reset in the middle of a run
        d0 = dones;
        a_in = 7'h55;
        b_in = 7'h0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) tick();
        chk("midrst_no_done", dones - d0, 0);
        chk("midrst_res", int'({res_and, res_or, res_xor, res_nand}), 0);
        run(7'h3C, 7'h5A);
        // start held high across two runs
        d0 = dones;
        t1 = -1;
        t2 = -1;
        a_in = 7'h55;
        b_in = 7'h0F;
        start = 1'b1;
        sbq.push_back(expect_of(7'h55, 7'h0F));
        sbq.push_back(expect_of(7'h2A, 7'h33));
        for (int i = 0; i < 12; i++) begin
            int dd;
            dd = dones;
            tick();
            if (i == 0) begin
                a_in = 7'h2A;
                b_in = 7'h33;
            end
            if (dones != dd) begin
                if (t1 < 0) t1 = i;
                else t2 = i;
            end
        end
        start = 1'b0;
        repeat (8) tick();
        chk("held_two_dones", dones - d0, 2);
        chk("held_first_done", t1, 5);
        chk("held_spacing", t2 - t1, 6);
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
